xsleena_video_timing: RTL and testbench

Synthesizable video timing generator for the Solar Warrior / Xain'd Sleena core. It divides the 48 MHz core clock into a 6 MHz pixel enable and runs the board's horizontal and vertical counters. The vertical counter follows the schematic sequence 08–FF, then E8–FF. It drives the sync, blank and screen-coordinate signals consumed by the tile/object/palette pipeline, by the RGB output stage, and by the frame-capture simulation bench.

---
 rtl/xsleena_video_pkg.sv | 28 ++
 rtl/xsleena_ce_gen.sv | 33 +++
 rtl/xsleena_video_timing.sv | 124 ++++++++++++
 tb/tb_xsleena_video_timing.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xsleena_video_pkg.sv
// Shared timing constants and the registered coordinate/sync bundle for the
// Xain'd Sleena video path.
package xsleena_video_pkg;

    localparam int unsigned HTotal = 384;
    localparam int unsigned VTotal = 272;

    // The vertical count runs 08..FF, then E8..FF.
    localparam logic [7:0] VcntPass0Start = 8'h08;
    localparam logic [7:0] VcntPass1Start = 8'hE8;
    localparam logic [7:0] VcntLast       = 8'hFF;

    localparam logic [7:0] BlkLast    = 8'hF7;
    localparam logic [7:0] DispFirst  = 8'h09;
    localparam logic [7:0] DispLast   = 8'hF6;
    localparam logic [7:0] VsyncFirst = 8'hF0;
    localparam logic [7:0] VsyncLast  = 8'hF7;

    typedef struct packed {
        logic [8:0] scr_x;
        logic [8:0] scr_y;
        logic       hsync;
        logic       vsync;
        logic       blk;
        logic       disp;
    } video_timing_t;

endpackage

// File: rtl/xsleena_ce_gen.sv
// Clock-enable divider: one-cycle registered pulse every CE_DIV clocks.
module xsleena_ce_gen #(
    parameter int unsigned CE_DIV = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic ce_o
);

    localparam int unsigned CntW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CE_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ce_q, ce_d;

    always_comb begin
        cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        ce_d  = (cnt_q == CntLast);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/xsleena_video_timing.sv
// Horizontal/vertical counters with registered sync, blank and coordinate outputs.
module xsleena_video_timing
    import xsleena_video_pkg::*;
#(
    parameter int unsigned CE_DIV       = 8,
    parameter int unsigned H_TOTAL      = HTotal,
    parameter int unsigned H_DISP_START = 8,
    parameter int unsigned H_DISP_END   = 263,
    parameter int unsigned H_SYNC_START = 296,
    parameter int unsigned H_SYNC_END   = 327
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       PIX_CE,
    output logic [8:0] SCR_X,
    output logic [8:0] SCR_Y,
    output logic [7:0] VCNT,
    output logic       VPASS,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       CSYNC,
    output logic       BLK,
    output logic       DISP,
    output logic       LINE_START,
    output logic       FRAME_START
);

    localparam logic [8:0] XLast     = 9'(H_TOTAL - 1);
    localparam logic [8:0] YLast     = 9'(VTotal - 1);
    localparam logic [8:0] HsStart   = 9'(H_SYNC_START);
    localparam logic [8:0] HsEnd     = 9'(H_SYNC_END);
    localparam logic [8:0] HdStart   = 9'(H_DISP_START);
    localparam logic [8:0] HdEnd     = 9'(H_DISP_END);

    localparam video_timing_t TimReset = '{
        scr_x: '0, scr_y: '0, hsync: 1'b0, vsync: 1'b1, blk: 1'b1, disp: 1'b0
    };

    logic pix_ce;

    xsleena_ce_gen #(
        .CE_DIV(CE_DIV)
    ) u_ce_gen (
        .clk_i(CLK),
        .rst_i(RST),
        .ce_o (pix_ce)
    );

    video_timing_t tim_q, tim_d;
    logic [7:0]    vcnt_q, vcnt_d;
    logic          vpass_q, vpass_d;
    logic          csync_q, csync_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // Decodes use the next-state counters so every output lines up with SCR_X/SCR_Y.
    always_comb begin
        tim_d         = tim_q;
        vcnt_d        = vcnt_q;
        vpass_d       = vpass_q;
        csync_d       = csync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_ce) begin
            if (tim_q.scr_x == XLast) begin
                tim_d.scr_x  = '0;
                line_start_d = 1'b1;
                if (tim_q.scr_y == YLast) begin
                    tim_d.scr_y   = '0;
                    frame_start_d = 1'b1;
                end else begin
                    tim_d.scr_y = tim_q.scr_y + 9'd1;
                end
                if (vcnt_q == VcntLast) begin
                    vcnt_d  = vpass_q ? VcntPass0Start : VcntPass1Start;
                    vpass_d = ~vpass_q;
                end else begin
                    vcnt_d = vcnt_q + 8'd1;
                end
            end else begin
                tim_d.scr_x = tim_q.scr_x + 9'd1;
            end

            tim_d.hsync = (tim_d.scr_x >= HsStart) && (tim_d.scr_x <= HsEnd);
            tim_d.vsync = !(vpass_d && (vcnt_d >= VsyncFirst) && (vcnt_d <= VsyncLast));
            tim_d.blk   = !vpass_d && (vcnt_d <= BlkLast);
            tim_d.disp  = (tim_d.scr_x >= HdStart) && (tim_d.scr_x <= HdEnd) && !vpass_d &&
                          (vcnt_d >= DispFirst) && (vcnt_d <= DispLast);
            csync_d     = ~(tim_d.hsync | ~tim_d.vsync);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tim_q         <= TimReset;
            vcnt_q        <= VcntPass0Start;
            vpass_q       <= 1'b0;
            csync_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            tim_q         <= tim_d;
            vcnt_q        <= vcnt_d;
            vpass_q       <= vpass_d;
            csync_q       <= csync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign PIX_CE      = pix_ce;
    assign SCR_X       = tim_q.scr_x;
    assign SCR_Y       = tim_q.scr_y;
    assign VCNT        = vcnt_q;
    assign VPASS       = vpass_q;
    assign HSYNC       = tim_q.hsync;
    assign VSYNC       = tim_q.vsync;
    assign CSYNC       = csync_q;
    assign BLK         = tim_q.blk;
    assign DISP        = tim_q.disp;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_xsleena_video_timing.sv
// Scoreboard bench: a default-parameter instance and a narrow-line instance share one reset.
module tb_xsleena_video_timing;

    localparam int unsigned VLines = 272;

    typedef struct packed {
        logic       pce;
        logic [8:0] x;
        logic [8:0] y;
        logic [7:0] vcnt;
        logic       vpass;
        logic       hs;
        logic       vs;
        logic       cs;
        logic       blk;
        logic       disp;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct {
        int unsigned edge_n;
        obs_t        s;
    } rec_t;

    int unsigned cfg_div [2] = '{8, 4};
    int unsigned cfg_ht  [2] = '{384, 16};
    int unsigned cfg_ds  [2] = '{8, 2};
    int unsigned cfg_de  [2] = '{263, 9};
    int unsigned cfg_hss [2] = '{296, 11};
    int unsigned cfg_hse [2] = '{327, 13};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       pce_a, vpass_a, hs_a, vs_a, cs_a, blk_a, disp_a, ls_a, fs_a;
    logic [8:0] x_a, y_a;
    logic [7:0] vcnt_a;
    logic       pce_b, vpass_b, hs_b, vs_b, cs_b, blk_b, disp_b, ls_b, fs_b;
    logic [8:0] x_b, y_b;
    logic [7:0] vcnt_b;

    xsleena_video_timing u_dut_a (
        .CLK(clk), .RST(rst), .PIX_CE(pce_a), .SCR_X(x_a), .SCR_Y(y_a), .VCNT(vcnt_a),
        .VPASS(vpass_a), .HSYNC(hs_a), .VSYNC(vs_a), .CSYNC(cs_a), .BLK(blk_a),
        .DISP(disp_a), .LINE_START(ls_a), .FRAME_START(fs_a)
    );

    xsleena_video_timing #(
        .CE_DIV(4), .H_TOTAL(16), .H_DISP_START(2), .H_DISP_END(9),
        .H_SYNC_START(11), .H_SYNC_END(13)
    ) u_dut_b (
        .CLK(clk), .RST(rst), .PIX_CE(pce_b), .SCR_X(x_b), .SCR_Y(y_b), .VCNT(vcnt_b),
        .VPASS(vpass_b), .HSYNC(hs_b), .VSYNC(vs_b), .CSYNC(cs_b), .BLK(blk_b),
        .DISP(disp_b), .LINE_START(ls_b), .FRAME_START(fs_b)
    );

    obs_t obs [2];
    always_comb begin
        obs[0] = {pce_a, x_a, y_a, vcnt_a, vpass_a, hs_a, vs_a, cs_a, blk_a, disp_a, ls_a, fs_a};
        obs[1] = {pce_b, x_b, y_b, vcnt_b, vpass_b, hs_b, vs_b, cs_b, blk_b, disp_b, ls_b, fs_b};
    end

    int unsigned edges = 0;
    always @(posedge clk) edges <= rst ? 0 : edges + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;
    rec_t        sb0 [$];
    rec_t        sb1 [$];
    logic [7:0]  vseq [$];

    bit          agg_en = 1'b0;
    int unsigned ls_cnt = 0, fs_cnt = 0, last_fs = 0, blk_lines = 0, vs_lines = 0;
    int unsigned disp_pix = 0, hs_pix = 0;

    task automatic check(input string name, input bit ok, input string act, input string exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s want %s", name, act, exp);
        end
    endtask

    function automatic string fmt(input obs_t o);
        return $sformatf("pce=%0d x=%0d y=%0d vcnt=%h vpass=%0d hs=%0d vs=%0d cs=%0d blk=%0d disp=%0d ls=%0d fs=%0d",
                         o.pce, o.x, o.y, o.vcnt, o.vpass, o.hs, o.vs, o.cs, o.blk, o.disp,
                         o.ls, o.fs);
    endfunction

    // Reference: screen state after k pixel steps, from line number arithmetic.
    function automatic obs_t model(input int unsigned i, input int unsigned k);
        obs_t        o;
        int unsigned x, line;
        x       = k % cfg_ht[i];
        line    = (k / cfg_ht[i]) % VLines;
        o.pce   = 1'b0;
        o.x     = 9'(x);
        o.y     = 9'(line);
        o.vpass = (line >= 248);
        o.vcnt  = o.vpass ? 8'(232 + line - 248) : 8'(8 + line);
        o.hs    = (x >= cfg_hss[i]) && (x <= cfg_hse[i]);
        o.vs    = !((line >= 256) && (line <= 263));
        o.cs    = !o.hs && o.vs;
        o.blk   = (line < 240);
        o.disp  = (x >= cfg_ds[i]) && (x <= cfg_de[i]) && (line >= 1) && (line <= 238);
        o.ls    = (k > 0) && (x == 0);
        o.fs    = o.ls && (line == 0);
        return o;
    endfunction

    task automatic cycle_check(input int unsigned i, input rec_t front, input bit prev,
                               output bit pulse);
        obs_t e;
        e     = front.s;
        e.pce = (edges == front.edge_n);
        e.ls  = prev & front.s.ls;
        e.fs  = prev & front.s.fs;
        check($sformatf("cycle_inst%0d_edge%0d", i, edges), obs[i] == e, fmt(obs[i]), fmt(e));
        pulse = e.pce;
    endtask

    initial begin : mon_a
        bit prev, pulse;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) prev = 1'b0;
            else if (sb0.size() == 0) check("underflow_inst0", 1'b0, "empty", "record");
            else begin
                cycle_check(0, sb0[0], prev, pulse);
                if (pulse) void'(sb0.pop_front());
                prev = pulse;
            end
        end
    end

    initial begin : mon_b
        bit prev, pulse;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) prev = 1'b0;
            else if (sb1.size() == 0) check("underflow_inst1", 1'b0, "empty", "record");
            else begin
                cycle_check(1, sb1[0], prev, pulse);
                if (pulse) void'(sb1.pop_front());
                prev = pulse;
            end
            if (!rst && agg_en) begin
                if (obs[1].ls) begin
                    check($sformatf("vcnt_at_line_start_%0d", ls_cnt),
                          obs[1].vcnt == vseq[ls_cnt % VLines],
                          $sformatf("%h", obs[1].vcnt), $sformatf("%h", vseq[ls_cnt % VLines]));
                    ls_cnt++;
                    if (obs[1].blk) blk_lines++;
                    if (!obs[1].vs) vs_lines++;
                end
                if (obs[1].fs) begin
                    if (fs_cnt > 0)
                        check("frame_spacing", edges - last_fs == 17408,
                              $sformatf("%0d", edges - last_fs), "17408");
                    last_fs = edges;
                    fs_cnt++;
                end
                if (obs[1].pce) begin
                    if (obs[1].disp) disp_pix++;
                    if (obs[1].hs) hs_pix++;
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++)
            check($sformatf("%s_inst%0d", tag, i), obs[i] == model(i, 0), fmt(obs[i]),
                  fmt(model(i, 0)));
    endtask

    // Schedules the expected pulses for a run of len clocks, then releases reset.
    task automatic release_run(input int unsigned len);
        rec_t r;
        @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            for (int unsigned j = 1; j <= len / cfg_div[i] + 1; j++) begin
                r.edge_n = j * cfg_div[i];
                r.s      = model(i, j - 1);
                if (i == 0) sb0.push_back(r);
                else sb1.push_back(r);
            end
        end
        rst = 1'b0;
        repeat (len) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input int unsigned hold);
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        check("leftover_inst0", sb0.size() == 1, $sformatf("%0d", sb0.size()), "1");
        check("leftover_inst1", sb1.size() == 1, $sformatf("%0d", sb1.size()), "1");
        sb0.delete();
        sb1.delete();
        repeat (hold) @(posedge clk);
    endtask

    initial begin : driver
        int unsigned xr;
        for (int v = 9; v <= 255; v++) vseq.push_back(8'(v));
        for (int v = 232; v <= 255; v++) vseq.push_back(8'(v));
        vseq.push_back(8'h08);

        repeat (3) @(posedge clk);
        #2;
        check_reset_values("power_up");

        // Three frames of the narrow instance with frame-level totals.
        agg_en = 1'b1;
        release_run(3 * VLines * 16 * 4 + 20);
        agg_en = 1'b0;
        check("line_starts", ls_cnt == 816, $sformatf("%0d", ls_cnt), "816");
        check("frame_starts", fs_cnt == 3, $sformatf("%0d", fs_cnt), "3");
        check("blk_lines", blk_lines == 720, $sformatf("%0d", blk_lines), "720");
        check("vsync_lines", vs_lines == 24, $sformatf("%0d", vs_lines), "24");
        check("disp_pixels", disp_pix == 5712, $sformatf("%0d", disp_pix), "5712");
        check("hsync_pixels", hs_pix == 2448, $sformatf("%0d", hs_pix), "2448");
        apply_reset(3);

        // Mid-frame reset on line 130 of the narrow instance.
        xr = $urandom_range(0, 15);
        release_run((130 * 16 + xr) * 4 + 1 + $urandom_range(0, 3));
        check("mid_frame_y", obs[1].y == 9'd130, $sformatf("%0d", obs[1].y), "130");
        check("mid_frame_x", obs[1].x == 9'(xr), $sformatf("%0d", obs[1].x),
              $sformatf("%0d", xr));
        apply_reset(3);

        release_run($urandom_range(1, 12));
        apply_reset($urandom_range(1, 4));
        repeat (3) begin
            release_run($urandom_range(20, 2500));
            apply_reset($urandom_range(1, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
